gshare_predictor: RTL and testbench

//  Parametrised direction predictor and successor to the fixed 1K x 2-bit local counter table.
//  - Table: DEPTH = 2**IDX_W saturating counters of CNT_W bits.
//  - Indexing: PC slice alone (MODE 0, bimodal) or PC slice XOR global history (MODE 1, gshare).
//  - Owns a speculative global history register (GHR) with mispredict recovery.
//  - Counters update by internal read-modify-write; callers never supply the old count.
//  - A reset sweep FSM initialises the table.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/sat_counter_next.sv | 19 +
 rtl/gshare_predictor.sv | 120 ++++++++++++
 tb/tb_gshare_predictor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: index modes, sweep FSM encoding and the
// PC/history index hash used by direction tables.
package bp_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Operands are zero-extended by the caller; the caller truncates the result
  // to its own index width.
  function automatic logic [31:0] bp_index(input logic [63:0] pc,
                                           input logic [31:0] ghr,
                                           input int          pc_lsb,
                                           input int          idx_w,
                                           input int          mode);
    logic [63:0] slice;
    slice = (pc >> pc_lsb) & ((64'd1 << idx_w) - 64'd1);
    if (mode == MODE_GSHARE) slice = slice ^ {32'd0, ghr};
    return slice[31:0];
  endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Combinational next value of a CNT_W-bit saturating up/down counter.
module sat_counter_next #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cur,
  input  logic             taken,
  output logic [CNT_W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != {CNT_W{1'b1}}) nxt = cur + CNT_W'(1);
    end else begin
      if (cur != '0) nxt = cur - CNT_W'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Bimodal/gshare direction predictor with speculative global history,
// mispredict recovery and a post-reset table initialisation sweep.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int PC_LSB   = 2,
  parameter int IDX_W    = 10,
  parameter int CNT_W    = 2,
  parameter int HIST_W   = 8,
  parameter int MODE     = MODE_GSHARE,
  parameter logic [CNT_W-1:0] INIT_VAL = CNT_W'(2**(CNT_W-1)-1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_ready,
  output logic              pred_taken,
  output logic [CNT_W-1:0]  pred_counter,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              cmt_valid,
  input  logic [PC_W-1:0]   cmt_pc,
  input  logic [HIST_W-1:0] cmt_ghr,
  input  logic              cmt_taken,
  input  logic              cmt_mispredict,
  output logic [31:0]       mispred_cnt
);

  localparam int DEPTH = 2**IDX_W;

  bp_state_e         state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [31:0]       mis_q, mis_d;

  logic [CNT_W-1:0]  cnt_tbl_q [DEPTH];

  logic [IDX_W-1:0]  pred_idx, cmt_idx, wr_idx;
  logic [CNT_W-1:0]  cmt_cur, cmt_nxt, wr_val, pred_cnt_c;
  logic              wr_en, run;

  assign run      = (state_q == ST_RUN);
  assign pred_idx = IDX_W'(bp_index(64'(pred_pc), 32'(ghr_q), PC_LSB, IDX_W, MODE));
  assign cmt_idx  = IDX_W'(bp_index(64'(cmt_pc), 32'(cmt_ghr), PC_LSB, IDX_W, MODE));
  assign cmt_cur  = cnt_tbl_q[cmt_idx];

  sat_counter_next #(.CNT_W(CNT_W)) u_sat (
    .cur   (cmt_cur),
    .taken (cmt_taken),
    .nxt   (cmt_nxt)
  );

  // Same-index commit is forwarded so fetch never sees a stale count.
  always_comb begin
    pred_cnt_c = cnt_tbl_q[pred_idx];
    if (cmt_valid && (cmt_idx == pred_idx)) pred_cnt_c = cmt_nxt;
    if (!run) pred_cnt_c = '0;
  end

  assign pred_ready   = run;
  assign pred_counter = pred_cnt_c;
  assign pred_taken   = pred_cnt_c[CNT_W-1];
  assign pred_ghr     = run ? ghr_q : '0;
  assign mispred_cnt  = mis_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned and a latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    mis_d   = mis_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_val  = INIT_VAL;
    case (state_q)
      ST_INIT: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH-1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cmt_valid) begin
          wr_en  = 1'b1;
          wr_idx = cmt_idx;
          wr_val = cmt_nxt;
        end
        // Recovery overrides the speculative shift of a same-cycle prediction.
        if (cmt_valid && cmt_mispredict) begin
          ghr_d = {cmt_ghr[HIST_W-2:0], cmt_taken};
          if (mis_q != 32'hFFFF_FFFF) mis_d = mis_q + 32'd1;
        end else if (pred_valid) begin
          ghr_d = {ghr_q[HIST_W-2:0], pred_taken};
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state is assigned with <= so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      mis_q   <= mis_d;
    end
  end

  // NOTE: the table has no reset; the INIT sweep initialises it, keeping reset off the array.
  always_ff @(posedge clk) begin
    if (wr_en) cnt_tbl_q[wr_idx] <= wr_val;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: stimulus pushes expected predictions
// into a queue, a negedge monitor pops and compares them.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        cmt_valid = 1'b0;
  logic [31:0] cmt_pc = '0;
  logic [7:0]  cmt_ghr = '0;
  logic        cmt_taken = 1'b0;
  logic        cmt_mispredict = 1'b0;
  logic        probe = 1'b0;

  logic        pred_ready, pred_taken;
  logic [1:0]  pred_counter;
  logic [7:0]  pred_ghr;
  logic [31:0] mispred_cnt;

  logic        b_ready, b_taken;
  logic [1:0]  b_counter;
  logic [7:0]  b_ghr;
  logic [31:0] b_mis;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] cnt;
    logic [7:0] ghr;
    string      tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  gshare_predictor #(.MODE(1)) dut (
    .clk(clk), .rstn(rstn),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_ready(pred_ready), .pred_taken(pred_taken),
    .pred_counter(pred_counter), .pred_ghr(pred_ghr),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_ghr(cmt_ghr),
    .cmt_taken(cmt_taken), .cmt_mispredict(cmt_mispredict),
    .mispred_cnt(mispred_cnt)
  );

  gshare_predictor #(.MODE(0)) dut_b (
    .clk(clk), .rstn(rstn),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_ready(b_ready), .pred_taken(b_taken),
    .pred_counter(b_counter), .pred_ghr(b_ghr),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_ghr(cmt_ghr),
    .cmt_taken(cmt_taken), .cmt_mispredict(cmt_mispredict),
    .mispred_cnt(b_mis)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the DUT presents a prediction the fetch side looks at.
  always @(negedge clk) begin
    if (rstn && pred_ready && (pred_valid || probe)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pred: got pc %0h with no expectation queued", pred_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_cnt"},   32'(pred_counter), 32'(e.cnt));
        check({e.tag, "_taken"}, 32'(pred_taken),   32'(e.cnt[1]));
        check({e.tag, "_ghr"},   32'(pred_ghr),     32'(e.ghr));
      end
    end
  end

  task automatic push(input logic [1:0] cnt, input logic [7:0] ghr, input string tag);
    exp_t e;
    e.cnt = cnt;
    e.ghr = ghr;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // All stimulus tasks start and end at posedge+1.
  task automatic do_probe(input logic [31:0] pc, input logic [1:0] cnt,
                          input logic [7:0] ghr, input string tag);
    pred_pc = pc;
    probe   = 1'b1;
    push(cnt, ghr, tag);
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic do_pred(input logic [31:0] pc, input logic [1:0] cnt,
                         input logic [7:0] ghr, input string tag);
    pred_pc    = pc;
    pred_valid = 1'b1;
    push(cnt, ghr, tag);
    @(posedge clk); #1;
    pred_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic [7:0] ghr,
                           input logic taken, input logic mis);
    cmt_valid      = 1'b1;
    cmt_pc         = pc;
    cmt_ghr        = ghr;
    cmt_taken      = taken;
    cmt_mispredict = mis;
    @(posedge clk); #1;
    cmt_valid      = 1'b0;
    cmt_mispredict = 1'b0;
  endtask

  // Reset and wait for the sweep while hammering both ports with traffic that must be ignored.
  task automatic reset_sweep(input int abort_at, input string tag);
    int n;
    pred_valid     = 1'b1;
    pred_pc        = 32'h80;
    cmt_valid      = 1'b1;
    cmt_pc         = 32'h40;
    cmt_ghr        = 8'hFF;
    cmt_taken      = 1'b1;
    cmt_mispredict = 1'b1;
    rstn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (abort_at > 0) begin
      rstn = 1'b1;
      repeat (abort_at) @(posedge clk);
      #1;
      check({tag, "_mid_ready"}, 32'(pred_ready), 32'd0);
      check({tag, "_mid_cnt"},   32'(pred_counter), 32'd0);
      rstn = 1'b0;
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    check({tag, "_ready_at_release"}, 32'(pred_ready), 32'd0);
    n = 0;
    while (!pred_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    pred_valid     = 1'b0;
    cmt_valid      = 1'b0;
    cmt_mispredict = 1'b0;
    check({tag, "_init_cycles"}, 32'(n), 32'd1024);
    check({tag, "_b_ready"}, 32'(b_ready), 32'd1);
    check({tag, "_mispred_cnt"}, mispred_cnt, 32'd0);
  endtask

  initial begin
    #1;
    // 1: sweep, then every entry reads weakly not-taken.
    reset_sweep(0, "rst1");
    do_probe(32'h0000_0000, 2'b01, 8'h00, "init_pc0");
    do_probe(32'h0000_0040, 2'b01, 8'h00, "init_pc40");
    do_probe(32'h0000_0ffc, 2'b01, 8'h00, "init_pcffc");
    do_probe(32'h1234_5678, 2'b01, 8'h00, "init_pcrand");

    // 2: saturating up then down at pc 0x40, ghr 0.
    do_commit(32'h40, 8'h00, 1'b1, 1'b0); do_probe(32'h40, 2'b10, 8'h00, "up1");
    do_commit(32'h40, 8'h00, 1'b1, 1'b0); do_probe(32'h40, 2'b11, 8'h00, "up2");
    do_commit(32'h40, 8'h00, 1'b1, 1'b0); do_probe(32'h40, 2'b11, 8'h00, "up3");
    do_commit(32'h40, 8'h00, 1'b1, 1'b0); do_probe(32'h40, 2'b11, 8'h00, "up4");
    do_commit(32'h40, 8'h00, 1'b0, 1'b0); do_probe(32'h40, 2'b10, 8'h00, "dn1");
    do_commit(32'h40, 8'h00, 1'b0, 1'b0); do_probe(32'h40, 2'b01, 8'h00, "dn2");
    do_commit(32'h40, 8'h00, 1'b0, 1'b0); do_probe(32'h40, 2'b00, 8'h00, "dn3");
    do_commit(32'h40, 8'h00, 1'b0, 1'b0); do_probe(32'h40, 2'b00, 8'h00, "dn4");

    // 3: speculative history 1,0,1 -> 0x05. Index 32 primed to strongly taken.
    do_commit(32'h80, 8'h00, 1'b1, 1'b0);
    do_commit(32'h80, 8'h00, 1'b1, 1'b0);
    do_pred(32'h80, 2'b11, 8'h00, "spec1");
    do_pred(32'h00, 2'b01, 8'h01, "spec2");
    do_pred(32'h88, 2'b11, 8'h02, "spec3");
    do_probe(32'h00, 2'b01, 8'h05, "spec_ghr");

    // 4: mispredict recovery beats a same-cycle accepted prediction.
    check("mis_before", mispred_cnt, 32'd0);
    pred_pc        = 32'h0;
    pred_valid     = 1'b1;
    push(2'b01, 8'h05, "rec_pred");
    cmt_valid      = 1'b1;
    cmt_pc         = 32'h100;
    cmt_ghr        = 8'h3C;
    cmt_taken      = 1'b0;
    cmt_mispredict = 1'b1;
    @(posedge clk); #1;
    pred_valid     = 1'b0;
    cmt_valid      = 1'b0;
    check("mis_after", mispred_cnt, 32'd1);
    cmt_ghr        = 8'hFF;
    cmt_taken      = 1'b1;
    do_probe(32'h0, 2'b01, 8'h78, "rec_ghr");
    cmt_mispredict = 1'b0;
    do_probe(32'h0, 2'b01, 8'h78, "rec_ghr_hold");
    check("mis_novalid", mispred_cnt, 32'd1);

    // 5: bypass. dut_b idx 16 goes 00 -> 01, then a same-cycle commit+probe.
    do_commit(32'h40, 8'h01, 1'b1, 1'b0);
    cmt_valid = 1'b1;
    cmt_pc    = 32'h40;
    cmt_ghr   = 8'h78;
    cmt_taken = 1'b1;
    pred_pc   = 32'h40;
    probe     = 1'b1;
    push(2'b10, 8'h78, "byp_gshare");
    @(negedge clk);
    check("byp_bimodal_cnt",   32'(b_counter), 32'd2);
    check("byp_bimodal_taken", 32'(b_taken),   32'd1);
    @(posedge clk); #1;
    cmt_valid = 1'b0;
    probe     = 1'b0;
    pred_pc   = 32'h40;
    probe     = 1'b1;
    push(2'b10, 8'h78, "byp_stored");
    @(negedge clk);
    check("byp_bimodal_stored", 32'(b_counter), 32'd2);
    @(posedge clk); #1;
    probe = 1'b0;

    // 6: reset mid-sweep restarts it; traffic during INIT writes nothing.
    reset_sweep(500, "rst2");
    do_probe(32'h40, 2'b01, 8'h00, "post_rst_pc40");
    do_probe(32'h80, 2'b01, 8'h00, "post_rst_pc80");

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
